// File: rtl/wishbone_initiator.sv
// wishbone_initiator
// Single-outstanding Wishbone classic initiator. Converts a valid/ready
// command into one bus cycle, retries on rty with a one-cycle backoff,
// bounds every attempt with a timeout and returns a one-cycle response
// carrying read data and a two-bit status code.

module wishbone_initiator #(
  parameter int RETRY_LIMIT = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_adr_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_dat_i,
  input  logic        cmd_we_i,

  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [3:0] RetryLimitC = 4'(RETRY_LIMIT);
  localparam logic [7:0] TimeoutC    = 8'(TIMEOUT);

  localparam logic [1:0] StatusOk             = 2'b00;
  localparam logic [1:0] StatusErr            = 2'b01;
  localparam logic [1:0] StatusRetryExhausted = 2'b10;
  localparam logic [1:0] StatusTimeout        = 2'b11;

  state_e      state_q, state_d;

  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;

  logic [3:0]  retryCnt_q, retryCnt_d;
  logic [7:0]  timeoutCnt_q, timeoutCnt_d;

  logic [31:0] rspDat_q, rspDat_d;
  logic [1:0]  rspStatus_q, rspStatus_d;

  logic        accept;
  logic        inBus;
  logic        retryExhausted;
  logic [7:0]  timeoutInc;
  logic        timeoutHit;

  // Qualifiers shared by the next-state and datapath logic. The timeout
  // compare uses the incremented value so that stb stays high for exactly
  // TIMEOUT cycles before the attempt is abandoned.
  assign accept         = cmd_valid_i && (state_q == IDLE);
  assign inBus          = (state_q == BUS);
  assign retryExhausted = (retryCnt_q == RetryLimitC);
  assign timeoutInc     = timeoutCnt_q + 8'd1;
  assign timeoutHit     = (timeoutInc == TimeoutC);

  // State register; reset abandons any bus cycle without a response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; terminations are only honoured in BUS, err > rty > ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          state_d = RESP;
        end else if (wb_rty_i) begin
          state_d = retryExhausted ? RESP : BACKOFF;
        end else if (wb_ack_i) begin
          state_d = RESP;
        end else if (timeoutHit) begin
          state_d = RESP;
        end
      end
      BACKOFF: begin
        state_d = BUS;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; all handshake outputs depend on the state register only.
  always_comb begin
    cmd_ready_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE:    cmd_ready_o = 1'b1;
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
      end
      BACKOFF: ;
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Payload capture: the command is latched once on accept and held stable
  // across every retry of the transaction.
  always_comb begin
    adr_d = adr_q;
    sel_d = sel_q;
    dat_d = dat_q;
    we_d  = we_q;
    if (accept) begin
      adr_d = cmd_adr_i;
      sel_d = cmd_sel_i;
      dat_d = cmd_dat_i;
      we_d  = cmd_we_i;
    end
  end

  // Retry and timeout counters; both restart per transaction, and the
  // timeout counter also restarts after each backoff cycle.
  always_comb begin
    retryCnt_d   = retryCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    if (accept) begin
      retryCnt_d   = 4'd0;
      timeoutCnt_d = 8'd0;
    end else if (inBus) begin
      if (wb_err_i) begin
        timeoutCnt_d = timeoutCnt_q;
      end else if (wb_rty_i) begin
        if (!retryExhausted) begin
          retryCnt_d = retryCnt_q + 4'd1;
        end
      end else if (!wb_ack_i) begin
        timeoutCnt_d = timeoutInc;
      end
    end else if (state_q == BACKOFF) begin
      timeoutCnt_d = 8'd0;
    end
  end

  // Response capture on the edge that leaves BUS; the values then hold
  // until the next response overwrites them.
  always_comb begin
    rspDat_d    = rspDat_q;
    rspStatus_d = rspStatus_q;
    if (inBus) begin
      if (wb_err_i) begin
        rspDat_d    = 32'd0;
        rspStatus_d = StatusErr;
      end else if (wb_rty_i) begin
        if (retryExhausted) begin
          rspDat_d    = 32'd0;
          rspStatus_d = StatusRetryExhausted;
        end
      end else if (wb_ack_i) begin
        rspDat_d    = we_q ? 32'd0 : wb_dat_i;
        rspStatus_d = StatusOk;
      end else if (timeoutHit) begin
        rspDat_d    = 32'd0;
        rspStatus_d = StatusTimeout;
      end
    end
  end

  // Datapath registers, cleared asynchronously together with the state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adr_q        <= 32'd0;
      sel_q        <= 4'd0;
      dat_q        <= 32'd0;
      we_q         <= 1'b0;
      retryCnt_q   <= 4'd0;
      timeoutCnt_q <= 8'd0;
      rspDat_q     <= 32'd0;
      rspStatus_q  <= StatusOk;
    end else begin
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      retryCnt_q   <= retryCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      rspDat_q     <= rspDat_d;
      rspStatus_q  <= rspStatus_d;
    end
  end

  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign rsp_dat_o    = rspDat_q;
  assign rsp_status_o = rspStatus_q;

endmodule

// File: tb/tb_wishbone_initiator.sv
// Testbench for wishbone_initiator: table-driven directed vectors, a few
// hand-written multi-cycle sequences and randomized transactions checked
// against a transaction-level reference model.

module tb_wishbone_initiator;

  localparam int RL = 2;
  localparam int TO = 16;
  localparam int BUDGET = 200;

  localparam int K_SIL    = 0;
  localparam int K_ACK    = 1;
  localparam int K_ERR    = 2;
  localparam int K_RTY    = 3;
  localparam int K_ACKERR = 4;
  localparam int K_ACKRTY = 5;
  localparam int K_ERRRTY = 6;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          k0, d0, k1, d1, k2, d2;
    logic [1:0]  expSt;
    logic [31:0] expDat;
    int          expWin;
    int          expStb;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_dat_i;
  logic        cmd_we_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  int vectors = 0;
  int miscompares = 0;
  int scrKind[8];
  int scrDelay[8];
  logic [31:0] lastExpDat = 32'd0;
  logic [1:0]  lastExpSt = 2'd0;
  vec_t vecs[11];

  wishbone_initiator #(.RETRY_LIMIT(RL), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i),
    .cmd_dat_i(cmd_dat_i), .cmd_we_i(cmd_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  function automatic bit isAck(input int k);
    return (k == K_ACK) || (k == K_ACKERR) || (k == K_ACKRTY);
  endfunction

  function automatic bit isErr(input int k);
    return (k == K_ERR) || (k == K_ACKERR) || (k == K_ERRRTY);
  endfunction

  function automatic bit isRty(input int k);
    return (k == K_RTY) || (k == K_ACKRTY) || (k == K_ERRRTY);
  endfunction

  // Comparison primitive shared by every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: walk the attempts of the responder script and
  // decide the outcome from termination priority, retry limit and timeout.
  task automatic refModel(input logic we, input logic [31:0] rdat,
                          output logic [1:0] st, output logic [31:0] dat,
                          output int windows, output int stbCycles);
    bit done;
    st = 2'b00; dat = 32'd0; windows = 0; stbCycles = 0; done = 0;
    for (int a = 0; a <= RL; a++) begin
      if (!done) begin
        windows++;
        if (!(isAck(scrKind[a]) || isErr(scrKind[a]) || isRty(scrKind[a])) || scrDelay[a] >= TO) begin
          stbCycles += TO; st = 2'b11; done = 1;
        end else begin
          stbCycles += scrDelay[a] + 1;
          if (isErr(scrKind[a])) begin
            st = 2'b01; done = 1;
          end else if (isRty(scrKind[a])) begin
            if (a == RL) begin st = 2'b10; done = 1; end
          end else begin
            st = 2'b00; dat = we ? 32'd0 : rdat; done = 1;
          end
        end
      end
    end
  endtask

  task automatic loadScript(input vec_t v);
    for (int i = 0; i < 8; i++) begin scrKind[i] = K_SIL; scrDelay[i] = 0; end
    scrKind[0] = v.k0; scrDelay[0] = v.d0;
    scrKind[1] = v.k1; scrDelay[1] = v.d1;
    scrKind[2] = v.k2; scrDelay[2] = v.d2;
  endtask

  // Issue one command and act as the responder cycle by cycle (decisions made
  // on the falling edge), then compare the observed transaction with v.
  task automatic applyStimulus(input vec_t v, input bit noise);
    int attempt, attCyc, windows, stbCycles, lowRun, rspCyc;
    bit prevStb, payloadBad, gapBad, gotRsp;
    logic [31:0] gotDat;
    logic [1:0] gotSt;
    attempt = 0; attCyc = 0; windows = 0; stbCycles = 0; lowRun = 0; rspCyc = 0;
    prevStb = 0; payloadBad = 0; gapBad = 0; gotRsp = 0; gotDat = '0; gotSt = '0;
    loadScript(v);
    checkOutput({v.name, ".rsp_dat_hold"}, rsp_dat_o, lastExpDat);
    checkOutput({v.name, ".rsp_st_hold"}, 32'(rsp_status_o), 32'(lastExpSt));
    checkOutput({v.name, ".cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_sel_i = v.sel; cmd_dat_i = v.wdat;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0; cmd_adr_i = $urandom; cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
    cmd_we_i = 1'($urandom);
    for (int cyc = 1; cyc <= BUDGET && !gotRsp; cyc++) begin
      if (wb_stb_o) begin
        if (!prevStb) begin
          windows++;
          if (windows > 1 && lowRun != 1) gapBad = 1;
        end
        attCyc++; stbCycles++; lowRun = 0;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== v.adr || wb_sel_o !== v.sel ||
            wb_dat_o !== v.wdat || wb_we_o !== v.we) payloadBad = 1;
        if (attempt < 8 && attCyc == scrDelay[attempt] + 1) begin
          wb_ack_i = isAck(scrKind[attempt]); wb_err_i = isErr(scrKind[attempt]);
          wb_rty_i = isRty(scrKind[attempt]);
          wb_dat_i = isAck(scrKind[attempt]) ? v.rdat : $urandom;
        end else begin
          wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = $urandom;
        end
      end else begin
        if (prevStb) begin attempt++; attCyc = 0; end
        lowRun++;
        if (wb_cyc_o !== 1'b0) payloadBad = 1;
        wb_ack_i = noise ? 1'($urandom) : 1'b0;
        wb_err_i = noise ? 1'($urandom) : 1'b0;
        wb_rty_i = noise ? 1'($urandom) : 1'b0;
        wb_dat_i = $urandom;
      end
      prevStb = wb_stb_o;
      if (rsp_valid_o) begin
        gotRsp = 1; rspCyc = cyc; gotDat = rsp_dat_o; gotSt = rsp_status_o;
      end else begin
        @(negedge clk_i);
      end
    end
    checkOutput({v.name, ".rsp_seen"}, 32'(gotRsp), 32'd1);
    checkOutput({v.name, ".status"}, 32'(gotSt), 32'(v.expSt));
    checkOutput({v.name, ".rsp_dat"}, gotDat, v.expDat);
    checkOutput({v.name, ".rsp_cycle"}, 32'(rspCyc), 32'(v.expStb + v.expWin));
    checkOutput({v.name, ".windows"}, 32'(windows), 32'(v.expWin));
    checkOutput({v.name, ".stb_cycles"}, 32'(stbCycles), 32'(v.expStb));
    checkOutput({v.name, ".payload"}, 32'(payloadBad), 32'd0);
    checkOutput({v.name, ".backoff_gap"}, 32'(gapBad), 32'd0);
    @(negedge clk_i);
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
    checkOutput({v.name, ".rsp_one_cycle"}, 32'(rsp_valid_o), 32'd0);
    checkOutput({v.name, ".ready_again"}, 32'(cmd_ready_o), 32'd1);
    lastExpDat = v.expDat;
    lastExpSt = v.expSt;
  endtask

  function automatic int randKind();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 40) return K_ACK;
    if (r < 50) return K_ERR;
    if (r < 75) return K_RTY;
    if (r < 80) return K_ACKERR;
    if (r < 90) return K_ACKRTY;
    if (r < 95) return K_SIL;
    return K_ERRRTY;
  endfunction

  function automatic int randDelay();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(TO - 2, TO + 1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    vec_t v;
    rst_n_i = 1'b0; cmd_valid_i = 0; cmd_adr_i = 0; cmd_sel_i = 0; cmd_dat_i = 0; cmd_we_i = 0;
    wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;

    vecs[0]  = '{"read_ok", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h1234_5678,
                 K_ACK, 1, K_SIL, 0, K_SIL, 0, 2'b00, 32'h1234_5678, 1, 2};
    vecs[1]  = '{"write_ok", 1'b1, 32'h0000_0020, 4'h3, 32'hDEAD_BEEF, 32'hFFFF_0000,
                 K_ACK, 1, K_SIL, 0, K_SIL, 0, 2'b00, 32'h0, 1, 2};
    vecs[2]  = '{"retry_then_ok", 1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'hA5A5_0001,
                 K_RTY, 1, K_RTY, 1, K_ACK, 1, 2'b00, 32'hA5A5_0001, 3, 6};
    vecs[3]  = '{"retry_exhausted", 1'b0, 32'h0000_2000, 4'hF, 32'h0, 32'h5555_AAAA,
                 K_RTY, 0, K_RTY, 0, K_RTY, 0, 2'b10, 32'h0, 3, 3};
    vecs[4]  = '{"timeout", 1'b0, 32'h0000_3000, 4'hF, 32'h0, 32'h7777_7777,
                 K_SIL, 0, K_SIL, 0, K_SIL, 0, 2'b11, 32'h0, 1, 16};
    vecs[5]  = '{"ack_err", 1'b0, 32'h0000_4000, 4'hF, 32'h0, 32'h1111_2222,
                 K_ACKERR, 1, K_SIL, 0, K_SIL, 0, 2'b01, 32'h0, 1, 2};
    vecs[6]  = '{"ack_rty", 1'b0, 32'h0000_5000, 4'hC, 32'h0, 32'h3333_4444,
                 K_ACKRTY, 0, K_ACK, 0, K_SIL, 0, 2'b00, 32'h3333_4444, 2, 2};
    vecs[7]  = '{"zero_wait", 1'b0, 32'hFFFF_FFFC, 4'h1, 32'h0, 32'hCAFE_F00D,
                 K_ACK, 0, K_SIL, 0, K_SIL, 0, 2'b00, 32'hCAFE_F00D, 1, 1};
    vecs[8]  = '{"ack_last_cycle", 1'b0, 32'h0000_6000, 4'hF, 32'h0, 32'h0BAD_CAFE,
                 K_ACK, 15, K_SIL, 0, K_SIL, 0, 2'b00, 32'h0BAD_CAFE, 1, 16};
    vecs[9]  = '{"timeout_reload", 1'b0, 32'h0000_7000, 4'hF, 32'h0, 32'h2468_ACE0,
                 K_RTY, 14, K_ACK, 14, K_SIL, 0, 2'b00, 32'h2468_ACE0, 2, 30};
    vecs[10] = '{"err_rty_write", 1'b1, 32'h0000_8000, 4'h6, 32'h0102_0304, 32'h9999_9999,
                 K_ERRRTY, 2, K_SIL, 0, K_SIL, 0, 2'b01, 32'h0, 1, 3};

    // Reset state
    repeat (3) @(negedge clk_i);
    checkOutput("reset.cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("reset.cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("reset.stb", 32'(wb_stb_o), 32'd0);
    checkOutput("reset.we", 32'(wb_we_o), 32'd0);
    checkOutput("reset.rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset.adr", wb_adr_o, 32'd0);
    checkOutput("reset.sel", 32'(wb_sel_o), 32'd0);
    checkOutput("reset.dat", wb_dat_o, 32'd0);
    checkOutput("reset.rsp_dat", rsp_dat_o, 32'd0);
    checkOutput("reset.rsp_status", 32'(rsp_status_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Directed table
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], 1'b0);

    // Reset asserted mid-transaction, away from any clock edge
    v = vecs[4];
    v.name = "pre_reset";
    loadScript(v);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h0000_ABCD; cmd_sel_i = 4'hF; cmd_dat_i = 32'h5A5A_5A5A;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("midreset.stb_before", 32'(wb_stb_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("midreset.cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("midreset.stb", 32'(wb_stb_o), 32'd0);
    checkOutput("midreset.ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("midreset.adr", wb_adr_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("midreset.no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("postreset.no_rsp", 32'(rsp_valid_o), 32'd0);
    checkOutput("postreset.ready", 32'(cmd_ready_o), 32'd1);
    lastExpDat = 32'd0;
    lastExpSt = 2'b00;
    v = vecs[0];
    v.name = "post_reset_read";
    applyStimulus(v, 1'b0);

    // Randomized transactions against the reference model, with noise on
    // the termination inputs whenever stb is low
    for (int n = 0; n < 60; n++) begin
      v.name = $sformatf("rand%0d", n);
      v.we = 1'($urandom); v.adr = $urandom; v.sel = 4'($urandom);
      v.wdat = $urandom; v.rdat = $urandom;
      v.k0 = randKind(); v.d0 = randDelay();
      v.k1 = randKind(); v.d1 = randDelay();
      v.k2 = randKind(); v.d2 = randDelay();
      loadScript(v);
      refModel(v.we, v.rdat, v.expSt, v.expDat, v.expWin, v.expStb);
      applyStimulus(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
